// File: rtl/vload_unit_pkg.sv
// ----------------------------------------------------------------------------
// vload_unit_pkg
// Shared constants and types for the vector load stage.
//   ELEM_W  : bits per vector element
//   NELEM   : elements per vector register
//   VEC_W   : packed vector width (ELEM_W*NELEM)
//   ADDR_W  : data-memory word address width
//   VREG_AW : vector register index width
//   LEN_W   : width of the element-count-minus-one field
//   vload_state_t : load sequencer states
// ----------------------------------------------------------------------------
package vload_unit_pkg;

   localparam int ELEM_W  = 16;
   localparam int NELEM   = 16;
   localparam int VEC_W   = ELEM_W * NELEM;
   localparam int ADDR_W  = 16;
   localparam int VREG_AW = 4;
   localparam int LEN_W   = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      WRITE = 2'd3
   } vload_state_t;

endpackage

// File: rtl/vload_unit_if.sv
// ----------------------------------------------------------------------------
// vload_unit_if
// Bundles the three buses seen by the vector load stage:
//   command : start, vd, base_addr, len  (from decode/issue)
//             busy, done                 (back to decode/issue)
//   memory  : mem_ren, mem_raddr (out), mem_rdata (in, 1-cycle latency)
//   regfile : v_wen, v_waddr, v_wlen, v_wdata (single write cycle)
// modport slave  : the load unit itself
// modport master : its environment (issue stage + data memory + regfile)
//
// Handshake: start is sampled only while busy=0; the command fields need only
// be valid in that acceptance cycle. busy rises the cycle after acceptance and
// stays high through the write cycle. done is a one-cycle pulse coincident
// with v_wen; v_waddr/v_wlen/v_wdata are valid and stable while v_wen=1.
// ----------------------------------------------------------------------------
interface vload_unit_if;
   import vload_unit_pkg::*;

   logic                 start;
   logic [VREG_AW-1:0]   vd;
   logic [ADDR_W-1:0]    base_addr;
   logic [LEN_W-1:0]     len;
   logic                 busy;
   logic                 done;
   logic                 mem_ren;
   logic [ADDR_W-1:0]    mem_raddr;
   logic [ELEM_W-1:0]    mem_rdata;
   logic                 v_wen;
   logic [VREG_AW-1:0]   v_waddr;
   logic [LEN_W-1:0]     v_wlen;
   logic [VEC_W-1:0]     v_wdata;

   modport slave (
      input  start, vd, base_addr, len, mem_rdata,
      output busy, done, mem_ren, mem_raddr, v_wen, v_waddr, v_wlen, v_wdata
   );

   modport master (
      output start, vd, base_addr, len, mem_rdata,
      input  busy, done, mem_ren, mem_raddr, v_wen, v_waddr, v_wlen, v_wdata
   );

endinterface

// File: rtl/vload_unit.sv
// ----------------------------------------------------------------------------
// vload_unit
// Vector load stage feeding the vector register file write port. On start it
// reads len+1 consecutive 16-bit words from data memory (one per cycle),
// packs them into a 256-bit vector (element i at bits [16*i+15:16*i], unused
// slots zero) and commits vector + length to the register file in one cycle.
// Ports:
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset
//   bus     : vload_unit_if.slave (command, memory and regfile buses)
//   o_state : current sequencer state, for observation only
// ----------------------------------------------------------------------------
module vload_unit
   import vload_unit_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   vload_unit_if.slave  bus,
   output vload_state_t o_state
);

   vload_state_t         r_state;
   vload_state_t         w_next_state;

   logic [VREG_AW-1:0]   r_vd;
   logic [ADDR_W-1:0]    r_base;
   logic [LEN_W-1:0]     r_len;
   logic [LEN_W-1:0]     r_issue_cnt;
   logic [LEN_W-1:0]     r_cap_cnt;
   logic                 r_cap_en;
   logic [ELEM_W-1:0]    r_buf [NELEM];
   logic [VEC_W-1:0]     w_wdata;
   logic                 w_accept;
   logic                 w_last_issue;

   assign w_accept     = (r_state == IDLE) && bus.start;
   assign w_last_issue = (r_issue_cnt == r_len);

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (bus.start)    w_next_state = ISSUE;
         ISSUE:   if (w_last_issue) w_next_state = DRAIN;
         DRAIN:                     w_next_state = WRITE;
         WRITE:                     w_next_state = IDLE;
         default:                   w_next_state = IDLE;
      endcase
   end

   // ------------------------------------------------------------------ outputs
   always_comb begin
      bus.busy      = 1'b0;
      bus.done      = 1'b0;
      bus.mem_ren   = 1'b0;
      bus.mem_raddr = '0;
      bus.v_wen     = 1'b0;
      case (r_state)
         ISSUE: begin
            bus.busy      = 1'b1;
            bus.mem_ren   = 1'b1;
            // 16-bit add wraps silently past 0xFFFF
            bus.mem_raddr = r_base + ADDR_W'(r_issue_cnt);
         end
         DRAIN: begin
            bus.busy = 1'b1;
         end
         WRITE: begin
            bus.busy  = 1'b1;
            bus.done  = 1'b1;
            bus.v_wen = 1'b1;
         end
         default: ;
      endcase
   end

   // Write address/length/data come straight from the latched registers, which
   // only change on acceptance or capture, so they are stable through WRITE.
   assign bus.v_waddr = r_vd;
   assign bus.v_wlen  = r_len;
   assign bus.v_wdata = w_wdata;
   assign o_state     = r_state;

   always_comb begin
      w_wdata = '0;
      for (int i = 0; i < NELEM; i++) begin
         w_wdata[i*ELEM_W +: ELEM_W] = r_buf[i];
      end
   end

   // ----------------------------------------------------------------- datapath
   // Capture runs one cycle behind issue: r_cap_en/r_cap_cnt are the issue
   // strobe and index delayed by one cycle, matching the memory read latency.
   // The final element is therefore captured at the end of DRAIN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vd        <= '0;
         r_base      <= '0;
         r_len       <= '0;
         r_issue_cnt <= '0;
         r_cap_cnt   <= '0;
         r_cap_en    <= 1'b0;
         for (int i = 0; i < NELEM; i++) begin
            r_buf[i] <= '0;
         end
      end else begin
         r_cap_en  <= (r_state == ISSUE);
         r_cap_cnt <= r_issue_cnt;

         if (r_cap_en) begin
            r_buf[r_cap_cnt] <= bus.mem_rdata;
         end

         if (w_accept) begin
            r_vd        <= bus.vd;
            r_base      <= bus.base_addr;
            r_len       <= bus.len;
            r_issue_cnt <= '0;
            r_cap_cnt   <= '0;
            // Clearing on acceptance keeps slots above len at zero and
            // prevents stale data from a previous load leaking through.
            for (int i = 0; i < NELEM; i++) begin
               r_buf[i] <= '0;
            end
         end else if ((r_state == ISSUE) && !w_last_issue) begin
            r_issue_cnt <= r_issue_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_vload_unit.sv
// ----------------------------------------------------------------------------
// tb_vload_unit
// Directed bench for vload_unit. Drivers push the expected read addresses and
// the expected register-file write into queues; a monitor on the falling edge
// pops and compares whenever the DUT reads memory or writes the regfile.
// ----------------------------------------------------------------------------
module tb_vload_unit;
   import vload_unit_pkg::*;

   localparam int EXP_W = VEC_W + VREG_AW + LEN_W + 32;

   logic          clk = 1'b0;
   logic          rst;
   vload_state_t  dbg_state;
   vload_unit_if  u_if ();

   vload_unit dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (u_if),
      .o_state (dbg_state)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   logic [EXP_W-1:0]  exp_q  [$];
   logic [ADDR_W-1:0] addr_q [$];
   int mem_mode = 0;
   bit chk_mem  = 1'b1;

   // ------------------------------------------------------------ memory model
   function automatic logic [ELEM_W-1:0] mem_f(input logic [ADDR_W-1:0] a, input int mode);
      case (mode)
         1:       mem_f = 16'hFFFF;
         2:       mem_f = 16'h1234;
         default: mem_f = a ^ 16'hA5A5;
      endcase
   endfunction

   always @(posedge clk) begin
      if (u_if.mem_ren) u_if.mem_rdata <= mem_f(u_if.mem_raddr, mem_mode);
   end

   function automatic logic [VEC_W-1:0] build_wdata(input logic [ADDR_W-1:0] base,
                                                    input int len, input int mode);
      logic [VEC_W-1:0] v;
      logic [ADDR_W-1:0] a;
      v = '0;
      for (int i = 0; i <= len; i++) begin
         a = base + ADDR_W'(i);
         v[i*ELEM_W +: ELEM_W] = mem_f(a, mode);
      end
      return v;
   endfunction

   task automatic check(input string name, input logic [VEC_W-1:0] act,
                        input logic [VEC_W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------ monitor
   always @(negedge clk) begin
      logic [EXP_W-1:0] e;
      if (!rst) begin
         if (u_if.mem_ren && chk_mem) begin
            if (addr_q.size() == 0) check("unexpected mem_ren", 1, 0);
            else check("mem_raddr", u_if.mem_raddr, addr_q.pop_front());
         end
         if (u_if.v_wen || u_if.done) begin
            check("done_eq_wen", u_if.done, u_if.v_wen);
         end
         if (u_if.v_wen) begin
            if (exp_q.size() == 0) begin
               check("unexpected v_wen", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("v_waddr", u_if.v_waddr, e[LEN_W+32 +: VREG_AW]);
               check("v_wlen",  u_if.v_wlen,  e[32 +: LEN_W]);
               check("v_wdata", u_if.v_wdata, e[VREG_AW+LEN_W+32 +: VEC_W]);
               check("write_cycle", cyc, e[31:0]);
               check("busy_in_write", u_if.busy, 1);
            end
         end
      end
   end

   // ------------------------------------------------------------------ drivers
   task automatic start_load(input logic [VREG_AW-1:0] vd, input logic [ADDR_W-1:0] base,
                             input int len, input int mode, input logic [VEC_W-1:0] wexp);
      @(negedge clk);
      mem_mode       = mode;
      u_if.start     = 1'b1;
      u_if.vd        = vd;
      u_if.base_addr = base;
      u_if.len       = LEN_W'(len);
      for (int i = 0; i <= len; i++) addr_q.push_back(base + ADDR_W'(i));
      @(posedge clk);
      #1;
      // Command fields are only needed in the acceptance cycle.
      u_if.start     = 1'b0;
      u_if.vd        = VREG_AW'($urandom_range(0, 15));
      u_if.base_addr = ADDR_W'($urandom_range(0, 65535));
      u_if.len       = LEN_W'($urandom_range(0, 15));
      exp_q.push_back({wexp, vd, LEN_W'(len), 32'(cyc + 32'(len) + 2)});
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || addr_q.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0 || addr_q.size() != 0) begin
         check({name, " timeout"}, 1, 0);
         exp_q.delete();
         addr_q.delete();
      end
   endtask

   task automatic wait_wen(input int budget);
      int n;
      n = 0;
      while (!u_if.v_wen && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!u_if.v_wen) check("wait v_wen timeout", 0, 1);
   endtask

   // ---------------------------------------------------------------- sequence
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst            = 1'b1;
      u_if.start     = 1'b0;
      u_if.vd        = '0;
      u_if.base_addr = '0;
      u_if.len       = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst busy",      u_if.busy,      0);
      check("rst done",      u_if.done,      0);
      check("rst mem_ren",   u_if.mem_ren,   0);
      check("rst mem_raddr", u_if.mem_raddr, 0);
      check("rst v_wen",     u_if.v_wen,     0);
      check("rst v_wdata",   u_if.v_wdata,   0);
      check("rst state",     dbg_state,      IDLE);
      @(negedge clk);
      rst = 1'b0;

      // 1: len=3 base=0x0100 vd=5, hand-computed slots
      start_load(4'd5, 16'h0100, 3, 0,
                 {192'h0, 16'hA4A6, 16'hA4A7, 16'hA4A4, 16'hA4A5});
      wait_drain("t1", 40);

      // 2: wrap past 0xFFFF, all 16 slots
      start_load(4'd2, 16'hFFF8, 15, 0, build_wdata(16'hFFF8, 15, 0));
      wait_drain("t2", 60);

      // 3: single element, 0x0042 ^ 0xA5A5 = 0xA5E7
      start_load(4'd15, 16'h0042, 0, 0, {240'h0, 16'hA5E7});
      wait_drain("t3", 40);

      // 4: full load of 0xFFFF, then a len=1 load the cycle after done
      start_load(4'd7, 16'h1000, 15, 1, {VEC_W{1'b1}});
      wait_wen(60);
      start_load(4'd8, 16'h2000, 1, 2, {224'h0, 16'h1234, 16'h1234});
      wait_drain("t4", 60);

      // 5: start pulsed mid-ISSUE with another vd must be ignored
      start_load(4'd5, 16'h0500, 3, 0, build_wdata(16'h0500, 3, 0));
      @(negedge clk);
      u_if.start     = 1'b1;
      u_if.vd        = 4'd9;
      u_if.base_addr = 16'h3000;
      u_if.len       = 4'd2;
      @(negedge clk);
      u_if.start     = 1'b0;
      wait_drain("t5", 40);
      repeat (10) @(negedge clk);

      // 6: reset in ISSUE cycle 2 of a len=7 load
      chk_mem = 1'b0;
      @(negedge clk);
      u_if.start     = 1'b1;
      u_if.vd        = 4'd3;
      u_if.base_addr = 16'h0300;
      u_if.len       = 4'd7;
      @(posedge clk);
      #1;
      u_if.start = 1'b0;
      @(posedge clk);
      #2;
      check("pre-rst mem_ren", u_if.mem_ren, 1);
      rst = 1'b1;
      #1;
      check("async busy",      u_if.busy,      0);
      check("async mem_ren",   u_if.mem_ren,   0);
      check("async mem_raddr", u_if.mem_raddr, 0);
      check("async v_wen",     u_if.v_wen,     0);
      check("async done",      u_if.done,      0);
      check("async v_waddr",   u_if.v_waddr,   0);
      check("async v_wlen",    u_if.v_wlen,    0);
      check("async state",     dbg_state,      IDLE);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (15) @(negedge clk);
      chk_mem = 1'b1;
      start_load(4'd5, 16'h0100, 3, 0,
                 {192'h0, 16'hA4A6, 16'hA4A7, 16'hA4A4, 16'hA4A5});
      wait_drain("t6", 40);
      repeat (5) @(negedge clk);

      check("exp_q empty",  exp_q.size(),  0);
      check("addr_q empty", addr_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
